// File: rtl/addac_div4.sv
// Sequential restoring divider: one quotient bit per clock via shift-and-subtract.
// Optional macro ADDAC_DIV_ZERO_CHECK_EN short-circuits a zero divisor to a 1-cycle result.
module addac_div4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: start is accepted on any rising edge where the block is in IDLE
  // or DONE (busy=0); operands are captured on that same edge. done pulses for
  // one cycle when quotient/remainder/div_by_zero take their new values, and
  // those outputs hold until the next accepted start completes or reset.

  state_e           state_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   t;
  logic [WIDTH+1:0] sum;
  logic             ge;
  logic [WIDTH-1:0] r_d, q_d;

  // Subtract by adding the inverted divisor with carry-in 1; carry-out means T >= D.
  assign t   = {r_q, q_q[WIDTH-1]};
  assign sum = {1'b0, t} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
  assign ge  = sum[WIDTH+1];
  assign r_d = ge ? sum[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_d = {q_q[WIDTH-2:0], ge};

  assign dbg_state = state_q;

`ifdef ADDAC_DIV_ZERO_CHECK_EN
  logic dz_q;
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef ADDAC_DIV_ZERO_CHECK_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_q   <= '0;
            q_q   <= dividend;
            d_q   <= divisor;
            cnt_q <= CW'(WIDTH-1);
`ifdef ADDAC_DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
              state_q   <= S_DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              dz_q      <= 1'b1;
            end else
`endif
            begin
              state_q <= S_RUN;
              busy    <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_d;
            remainder <= r_d;
`ifdef ADDAC_DIV_ZERO_CHECK_EN
            dz_q      <= 1'b0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addac_div4.sv
// Bench for addac_div4: arithmetic reference model checked every cycle, plus
// directed literal cases and a shuffled sweep of every dividend/divisor pair.
module tb_addac_div4;
  localparam int W = 4;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  addac_div4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef ADDAC_DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  // reference model: results from plain division, timing as a countdown
  logic [2*W:0] exp_q[$];
  bit           m_busy = 0, m_done = 0, m_dz = 0;
  logic [W-1:0] m_q = '0, m_r = '0;
  int           m_left = 0;

  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit dz);
    if (b == 0) return {dz, ONES, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  always @(posedge clk) begin
    logic [2*W:0] e;
    if (rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_left = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {m_dz, m_q, m_r} = e;
          end
        end
      end else if (start) begin
        if (ZCHK && divisor == 0) begin
          m_done = 1;
          {m_dz, m_q, m_r} = ref_div(dividend, divisor, 1'b1);
        end else begin
          m_busy = 1;
          m_left = W;
          exp_q.push_back(ref_div(dividend, divisor, 1'b0));
        end
      end
    end
  end

  // compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (armed) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div_by_zero", div_by_zero, m_dz);
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check("done_timeout", 0, 1);
  endtask

  int lat, pulses, last, gap;
  logic [W-1:0] pa[256], pb[256];

  initial begin
    idle(1);
    @(posedge clk); #1 armed = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    rst = 1'b0;
    idle(1);

    // 13/3 -> 4,1 with latency W+1
    run_op(4'd13, 4'd3, lat);
    check("lat_13_3", lat, 5);
    check("q_13_3", quotient, 4);
    check("r_13_3", remainder, 1);
    idle(3);
    check("hold_q", quotient, 4);
    run_op(4'd15, 4'd1, lat);
    check("q_15_1", quotient, 15);
    check("r_15_1", remainder, 0);
    idle(2);
    run_op(4'd2, 4'd7, lat);
    check("q_2_7", quotient, 0);
    check("r_2_7", remainder, 2);
    run_op(4'd0, 4'd5, lat);
    check("q_0_5", quotient, 0);
    check("r_0_5", remainder, 0);

    // start held high: accepted only in IDLE/DONE, done every W+1 cycles
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    pulses = 0; last = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done) begin
        check("q_9_2", quotient, 4);
        check("r_9_2", remainder, 1);
        if (pulses > 0) begin
          gap = c - last;
          check("b2b_gap", gap, 5);
        end
        pulses++;
        last = c;
      end
    end
    check("b2b_pulses", pulses, 3);
    start = 1'b0;
    idle(6);

    // reset in the middle of RUN discards the operation
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("no_done_after_rst", pulses, 0);
    run_op(4'd13, 4'd3, lat);
    check("q_13_3_again", quotient, 4);
    check("r_13_3_again", remainder, 1);

    // divide by zero
    run_op(4'd9, 4'd0, lat);
    check("q_9_0", quotient, 15);
    check("r_9_0", remainder, 9);
    check("lat_9_0", lat, ZCHK ? 1 : 5);
    check("dz_9_0", div_by_zero, ZCHK ? 1 : 0);
    run_op(4'd7, 4'd2, lat);
    check("dz_cleared", div_by_zero, 0);

    // shuffled sweep of all pairs
    for (int i = 0; i < 256; i++) begin
      pa[i] = W'(i >> 4);
      pb[i] = W'(i & 15);
    end
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [W-1:0] ta, tb;
      j = $urandom_range(i, 0);
      ta = pa[i]; pa[i] = pa[j]; pa[j] = ta;
      tb = pb[i]; pb[i] = pb[j]; pb[j] = tb;
    end
    for (int i = 0; i < 256; i++) begin
      run_op(pa[i], pb[i], lat);
      if (pb[i] != 0) begin
        check("sweep_identity", 32'(quotient) * 32'(pb[i]) + 32'(remainder), 32'(pa[i]));
        check("sweep_rem_lt", (remainder < pb[i]) ? 1 : 0, 1);
      end
      if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 0));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
